// File: rtl/sram_pkg.sv
// Shared definitions for the data-SRAM response model.
//   - sram_size_e  : request size encodings (1, 2 or 4 bytes)
//   - resp_entry_t : one in-order response queue entry
//   - LfsrSeed / LfsrTaps / lfsr_next : random-delay LFSR
//     (used only when DATA_SRAM_RAND_DELAY_EN is defined)
package sram_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } sram_size_e;

  // Wide enough for LAT (max 15) plus up to 3 extra random cycles.
  localparam int unsigned AgeW = 5;
  typedef logic [AgeW-1:0] age_t;
  localparam age_t AgeOne = age_t'(1);

  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
    logic [1:0]  extra;  // extra latency cycles added to this entry's threshold
    age_t        age;
  } resp_entry_t;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LfsrTaps)};
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue with a per-entry age counter.
//   clk, reset      : clock, synchronous active-high reset
//   push/push_entry : enqueue an entry (age forced to 0)
//   pop             : dequeue the head entry
//   full/empty/count: occupancy status
//   head/head_ready : head entry and "age reached its threshold"
// Each entry's age saturates at Lat + entry.extra.
module sram_resp_fifo
  import sram_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Lat   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  resp_entry_t              push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count,
  output resp_entry_t              head,
  output logic                     head_ready
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(Depth);

  resp_entry_t     entries_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;

  function automatic age_t threshold(input logic [1:0] extra);
    return age_t'(Lat) + age_t'(extra);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (entries_q[i].age < threshold(entries_q[i].extra)) begin
          entries_q[i].age <= entries_q[i].age + AgeOne;
        end
      end
      // Later assignment overrides the aging of the slot being written.
      if (push) begin
        entries_q[wr_ptr_q]     <= push_entry;
        entries_q[wr_ptr_q].age <= '0;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: ;
      endcase
    end
  end

  always_comb begin
    head       = entries_q[rd_ptr_q];
    empty      = (count_q == '0);
    full       = (count_q == CntFull);
    count      = count_q;
    head_ready = !empty && (head.age >= threshold(head.extra));
  end

endmodule

// File: rtl/data_sram_resp.sv
// Behavioural data-SRAM slave with an addr_ok/data_ok handshake.
//   clk, reset        : clock, synchronous active-high reset
//   data_sram_req     : request valid, held until data_sram_addr_ok
//   data_sram_wr      : 1 = write, 0 = read
//   data_sram_size    : access size (informational; reads return full word)
//   data_sram_wstrb   : byte enables for writes
//   data_sram_addr    : byte address, word index wraps at MEM_WORDS
//   data_sram_wdata   : lane-aligned write data
//   data_sram_addr_ok : request accepted this cycle
//   data_sram_data_ok : one response per request, in acceptance order
//   data_sram_rdata   : read word on a read response, else 0
// Optional: define DATA_SRAM_RAND_DELAY_EN to randomly throttle addr_ok and
// add 0-3 cycles to each response latency, driven by a 16-bit LFSR.
module data_sram_resp
  import sram_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LAT       = 2,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned WordAw = $clog2(MEM_WORDS);

  logic [31:0]         mem_q [MEM_WORDS];
  logic [WordAw-1:0]   word_idx;
  logic                accept;
  logic                gate;
  logic [1:0]          extra;
  resp_entry_t         push_entry;
  resp_entry_t         head;
  logic                head_ready;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(QDEPTH):0] fifo_count;

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign gate  = lfsr_q[0];
  assign extra = lfsr_q[2:1];
`else
  assign gate  = 1'b1;
  assign extra = 2'b00;
`endif

  assign word_idx = data_sram_addr[WordAw+1:2];

  // Full is judged on start-of-cycle occupancy; a retire in the same cycle
  // does not free a slot until the next cycle.
  assign data_sram_addr_ok = !reset && !fifo_full && gate;
  assign accept            = data_sram_req && data_sram_addr_ok;

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads snapshot the word at acceptance, so earlier accepted writes are seen.
  always_comb begin
    push_entry          = '0;
    push_entry.is_write = data_sram_wr;
    push_entry.rdata    = data_sram_wr ? 32'h0 : mem_q[word_idx];
    push_entry.extra    = extra;
  end

  sram_resp_fifo #(
    .Depth (QDEPTH),
    .Lat   (LAT)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (data_sram_data_ok),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (head),
    .head_ready (head_ready)
  );

  always_comb begin
    data_sram_data_ok = !reset && head_ready;
    data_sram_rdata   = (data_sram_data_ok && !head.is_write) ? head.rdata : 32'h0;
  end

  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:WordAw+2], data_sram_addr[1:0],
                         fifo_empty, fifo_count, head.age, head.extra};

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  localparam int LatA = 2;
`ifdef DATA_SRAM_RAND_DELAY_EN
  localparam int MaxExtra = 3;
`else
  localparam int MaxExtra = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        req_b, addr_ok_b, data_ok_b;
  logic [31:0] rdata_b;

  data_sram_resp dut (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  data_sram_resp #(
    .MEM_WORDS (64),
    .LAT       (15),
    .QDEPTH    (4)
  ) dut_b (
    .clk               (clk),
    .reset             (reset),
    .data_sram_req     (req_b),
    .data_sram_wr      (1'b0),
    .data_sram_size    (2'd2),
    .data_sram_wstrb   (4'h0),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok_b),
    .data_sram_data_ok (data_ok_b),
    .data_sram_rdata   (rdata_b)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] mdl [1024];
  logic [31:0] exp_data[$];
  int          exp_t[$];
  bit          accepted;
  logic [31:0] last_rdata;
  bit          b_active = 0;
  int          b_cyc;
  int          b_ret[$];
  int          b_accepts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampled at the falling edge: scoreboard responses, model acceptances.
  task automatic observe();
    accepted = 0;
    if (reset) begin
      check("reset_addr_ok", 32'(addr_ok), 32'd0);
      check("reset_data_ok", 32'(data_ok), 32'd0);
      check("reset_rdata", rdata, 32'd0);
    end else begin
      if (data_ok) begin
        if (exp_t.size() == 0) begin
          check("spurious_data_ok", 32'(data_ok), 32'd0);
        end else begin
          int lat;
          lat = cyc - exp_t[0];
          check("resp_rdata", rdata, exp_data[0]);
          check("resp_lat_min", 32'(lat >= LatA), 32'd1);
          check("resp_lat_max", 32'(lat <= LatA + MaxExtra), 32'd1);
          last_rdata = rdata;
          void'(exp_t.pop_front());
          void'(exp_data.pop_front());
        end
      end else begin
        check("idle_rdata", rdata, 32'd0);
        if (exp_t.size() > 0 && (cyc - exp_t[0]) >= LatA + MaxExtra) begin
          check("missing_data_ok", 32'(data_ok), 32'd1);
          void'(exp_t.pop_front());
          void'(exp_data.pop_front());
        end
      end
      if (req && addr_ok) begin
        int idx;
        idx = int'(addr[11:2]);
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
          end
          exp_data.push_back(32'h0);
        end else begin
          exp_data.push_back(mdl[idx]);
        end
        exp_t.push_back(cyc + 1);
        accepted = 1;
      end
    end
    if (b_active) begin
      bit exp_ok, exp_dok;
      while (b_ret.size() > 0 && b_ret[0] < b_cyc) void'(b_ret.pop_front());
      exp_ok  = (b_ret.size() < 4);
      exp_dok = (b_ret.size() > 0 && b_ret[0] == b_cyc);
      check("b_addr_ok", 32'(addr_ok_b), 32'(exp_ok));
      check("b_data_ok", 32'(data_ok_b), 32'(exp_dok));
      if (exp_ok) b_ret.push_back(b_cyc + 16);
      if (b_cyc < 16 && addr_ok_b) b_accepts++;
      b_cyc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] sz);
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = sz;
    for (int n = 0; n < 100; n++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    req = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_t.size() == 0) break;
      step();
    end
    check("drain_timeout", 32'(exp_t.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req_b = 1'b0; wr = 1'b0; size = 2'd2;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; last_rdata = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("post_reset_data_ok", 32'(data_ok), 32'd0);

    // Known contents for the words used below.
    for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), 32'h0, 4'hF, 2'd2);
    do_req(1'b1, 32'h100, 32'h0, 4'hF, 2'd2);
    drain();

    // Full-word write then read back.
    do_req(1'b1, 32'h100, 32'h11223344, 4'hF, 2'd2);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 2'd2);
    drain();
    check("w_then_r", last_rdata, 32'h11223344);

    // Partial strobes; a zero-strobe write still responds but changes nothing.
    do_req(1'b1, 32'h100, 32'h0, 4'hF, 2'd2);
    do_req(1'b1, 32'h102, 32'hAABBCCDD, 4'b1100, 2'd1);
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 2'd2);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 2'd1);
    drain();
    check("strobe_upper_half", last_rdata, 32'hAABB0000);

    // Address wrap and unshifted byte read.
    do_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 2'd2);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 2'd2);
    drain();
    check("addr_wrap", last_rdata, 32'h5A5A5A5A);
    do_req(1'b0, 32'h0000_1003, 32'h0, 4'h0, 2'd0);
    drain();
    check("byte_read_unshifted", last_rdata, 32'h5A5A5A5A);

`ifndef DATA_SRAM_RAND_DELAY_EN
    // Held request into a LAT=15, depth-4 queue.
    b_cyc = 0; b_accepts = 0; b_ret.delete();
    req_b = 1'b1; b_active = 1;
    repeat (40) step();
    req_b = 1'b0; b_active = 0;
    check("b_accepts_before_retire", 32'(b_accepts), 32'd4);
`endif

    // Reset with three requests in flight.
    do_req(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 2'd2);
    do_req(1'b0, 32'h200, 32'h0, 4'h0, 2'd2);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 2'd2);
    exp_t.delete(); exp_data.delete();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (25) step();
    do_req(1'b0, 32'h200, 32'h0, 4'h0, 2'd2);
    drain();
    check("mem_persists_reset", last_rdata, 32'hCAFEF00D);

    // Random traffic over the zeroed region, with random high/low address bits.
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] r, d;
      logic [4:0]  idx;
      if ($urandom_range(0, 3) == 0) step();
      r   = $urandom();
      d   = $urandom();
      idx = 5'($urandom_range(0, 31));
      do_req(1'($urandom_range(0, 1)), {r[31:12], 5'b0, idx, r[1:0]}, d,
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
